vga_write_arbiter: RTL and testbench
====================================

# vga_write_arbiter

Shares the single pixel-write port of the VGA adapter between several drawing engines: greeting-screen renderer, playfield renderer, game-over renderer and screen clearer. Requesters raise a request, receive a registered one-hot grant, and stream pixels while granted. Grants rotate round-robin so no renderer starves. Sits between the renderers and the VGA adapter; the game state FSM drives `enable`.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `X_W`, 8: x coordinate width.
- `Y_W`, 7: y coordinate width.
- `COLOR_W`, 3: colour width.
- `SCREEN_W`, 160: pixels with x ≥ SCREEN_W are dropped.
- `SCREEN_H`, 120: pixels with y ≥ SCREEN_H are dropped.
- `MAX_HOLD`, 64: grant-cycle limit; used only with `VGA_ARB_TIMEOUT_EN`.

Ports:
- `clock` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: when high, new grants may be issued. When low, forces release.
- `req` in N_REQ: per-requester request, level-sensitive.
- `req_plot` in N_REQ: per-requester pixel-valid strobe.
- `req_x` in N_REQ*X_W: packed x; slice i = `[i*X_W +: X_W]`.
- `req_y` in N_REQ*Y_W: packed y.
- `req_colour` in N_REQ*COLOR_W: packed colour.
- `gnt` out N_REQ: registered one-hot grant; at most one bit set.
- `vga_x` out X_W: registered pixel x to adapter.
- `vga_y` out Y_W: registered pixel y.
- `vga_colour` out COLOR_W: registered colour.
- `vga_plot` out 1: registered write strobe.

## Operation
- States: IDLE and BUSY. Registers: `owner` (index), `last` (previous owner), `hold_cnt`.
- Reset values:
  - state IDLE; `gnt`=0; `last`=N_REQ-1, so requester 0 wins first.
  - `hold_cnt`=0; `vga_x`, `vga_y`, `vga_colour` and `vga_plot` all 0.
- IDLE → BUSY: when `enable`=1 and `req`≠0.
  - `owner` = first set `req` bit scanning last+1, last+2, … modulo N_REQ.
  - `gnt` ← onehot(owner); `hold_cnt` ← 0.
- BUSY, datapath: every cycle, `vga_x/y/colour` ← slices of `owner`.
  - `vga_plot` ← `req_plot[owner]` & x<SCREEN_W & y<SCREEN_H.
  - Out-of-range pixels still update the coordinate and colour registers; only the strobe is suppressed.
- BUSY → IDLE (release) on any of:
  - `req[owner]`=0;
  - `enable`=0;
  - timeout (see Configuration).
- On release: `gnt` ← 0, `last` ← owner.
  - The pixel presented in the release cycle is still forwarded (gnt was high that cycle).
- In IDLE: `vga_plot` ← 0; coordinate and colour registers hold their values.
- `req_plot` from non-owners is ignored in all states.
- `req` bits may change at any time. Only the value sampled in IDLE matters for selection.
- `enable`=0 in IDLE: no grant is issued; requests stay pending.
- Asynchronous reset mid-burst: all registers return to reset values immediately. The interrupted requester must re-request.

## Timing
- Grant latency: `req` sampled high in IDLE → `gnt` high on the next edge (1 cycle).
- Pixel latency: `req_*` presented in cycle n while granted → `vga_*` valid after edge n+1 (1 cycle).
- Handoff: a release cycle, then one IDLE cycle, then the new grant.
  - Minimum 1 idle cycle on `vga_plot` between owners.
  - Back-to-back same requester is allowed only via IDLE, with the same bubble.
- Throughput: 1 pixel/clock during a grant.
- Requester contract: `req_plot` is asserted only in cycles where its `gnt` bit is high.

## Configuration
- Macro: `VGA_ARB_TIMEOUT_EN`.
- Defined:
  - `hold_cnt` increments each BUSY cycle, saturating at MAX_HOLD-1.
  - When `hold_cnt`=MAX_HOLD-1 and any other `req` bit is set, the owner is released that cycle.
  - With no competitor, the owner keeps the grant indefinitely.
- Undefined:
  - No counter logic is present.
  - The owner holds the grant until `req[owner]`=0 or `enable`=0.

## Test plan
- Reset/first grant: hold resetn=0, then release with enable=1, req=4'b0101 → all outputs 0 during reset; `gnt`=4'b0001 one cycle after release.
- Pixel pass-through: requester 2 alone, plot (x=5, y=7, colour=3) while granted → next cycle vga_x=5, vga_y=7, vga_colour=3, vga_plot=1. A simultaneous `req_plot[0]`=1 has no effect.
- Round-robin: req=4'b1111 held, each owner drops req after 3 pixels → grant order 0,1,2,3,0; exactly one idle `vga_plot` cycle per handoff.
- Bounds: owner plots x=160, y=10, then x=159, y=119 → vga_plot=0, then 1; vga_x shows 160 then 159.
- Enable drop: enable→0 mid-burst of requester 1 → `gnt` clears next edge, last=1. enable→1 with req=4'b0011 → requester 0 granted.
- Timeout (macro defined, MAX_HOLD=8): req0 held from cycle 0, req1 raised at cycle 2 → gnt0 high for exactly 8 cycles, one idle cycle, then gnt=4'b0010. Without the macro, gnt0 persists.

Source files
------------

// File: rtl/vga_write_arbiter.sv
// Round-robin owner of the VGA pixel-write port: 1-cycle grant latency, 1-cycle pixel latency, one idle bubble between owners.
// Optional VGA_ARB_TIMEOUT_EN releases an owner after MAX_HOLD grant cycles when another requester is waiting.
module vga_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int MAX_HOLD = 64
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_plot,
  input  logic [N_REQ*X_W-1:0]     req_x,
  input  logic [N_REQ*Y_W-1:0]     req_y,
  input  logic [N_REQ*COLOR_W-1:0] req_colour,
  output logic [N_REQ-1:0]         gnt,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COLOR_W-1:0]       vga_colour,
  output logic                     vga_plot
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
  localparam logic [X_W:0] X_LIM = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(SCREEN_H);

  if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 2) begin : g_bad_param
    $error("vga_write_arbiter: unsupported parameter set");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [X_W-1:0]     vga_x_q, vga_x_d;
  logic [Y_W-1:0]     vga_y_q, vga_y_d;
  logic [COLOR_W-1:0] vga_colour_q, vga_colour_d;
  logic               vga_plot_q, vga_plot_d;

  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic               start;
  logic               release_now;
  logic               timeout;
  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;
  logic [COLOR_W-1:0] pix_colour;
  logic               in_range;

  // Rotating priority: scan starts just after the previous owner.
  always_comb begin
    sel_idx   = last_q;
    sel_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      int cand;
      cand = int'(last_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!sel_found && req[cand]) begin
        sel_idx   = IDX_W'(cand);
        sel_found = 1'b1;
      end
    end
  end

  assign start       = (state_q == IDLE) && enable && sel_found;
  assign release_now = !req[owner_q] || !enable || timeout;

  assign pix_x      = req_x[owner_q*X_W +: X_W];
  assign pix_y      = req_y[owner_q*Y_W +: Y_W];
  assign pix_colour = req_colour[owner_q*COLOR_W +: COLOR_W];
  assign in_range   = ({1'b0, pix_x} < X_LIM) && ({1'b0, pix_y} < Y_LIM);

`ifdef VGA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] owner_oh;

  assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
  // Only yield when someone else is actually waiting.
  assign timeout  = (hold_cnt_q == CNT_MAX) && |(req & ~owner_oh);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (start) begin
      hold_cnt_d = '0;
    end else if (state_q == BUSY && hold_cnt_q != CNT_MAX) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) hold_cnt_q <= '0;
    else         hold_cnt_q <= hold_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = BUSY;
      BUSY: if (release_now) state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          owner_d = sel_idx;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
        end
      end
      BUSY: begin
        // The release-cycle pixel is still forwarded since gnt was high for it.
        vga_x_d      = pix_x;
        vga_y_d      = pix_y;
        vga_colour_d = pix_colour;
        vga_plot_d   = req_plot[owner_q] && in_range;
        if (release_now) begin
          gnt_d  = '0;
          last_d = owner_q;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      owner_q      <= '0;
      last_q       <= LAST_RST;
      gnt_q        <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign gnt        = gnt_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter: vector table plus reset, round-robin and hold-limit sequences.
module tb_vga_write_arbiter;

  logic        clock;
  logic        resetn;
  logic        enable;
  logic [3:0]  req;
  logic [3:0]  req_plot;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [11:0] req_colour;
  logic [3:0]  gnt;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int total;
  int bad;

  vga_write_arbiter #(
    .N_REQ(4), .X_W(8), .Y_W(7), .COLOR_W(3),
    .SCREEN_W(160), .SCREEN_H(120), .MAX_HOLD(8)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .req(req), .req_plot(req_plot),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .gnt(gnt), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic [3:0] rq;
    logic [3:0] pl;
    int         src;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [3:0] e_gnt;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_c;
    logic       e_p;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  // Selected requester sees (x,y,c); the others present distinct decoy pixels.
  task automatic drive(input logic en, input logic [3:0] rq, input logic [3:0] pl,
                       input int src, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    enable   = en;
    req      = rq;
    req_plot = pl;
    for (int i = 0; i < 4; i++) begin
      req_x[i*8 +: 8]      = (i == src) ? x : 8'(90 + i);
      req_y[i*7 +: 7]      = (i == src) ? y : 7'(100 + i);
      req_colour[i*3 +: 3] = (i == src) ? c : 3'(7 - i);
    end
  endtask

  task automatic step_check(input string tag, input int idx,
                            input logic [3:0] e_gnt, input logic [7:0] e_x, input logic [6:0] e_y,
                            input logic [2:0] e_c, input logic e_p);
    @(posedge clock);
    #1;
    check({tag, ".gnt"}, idx, 32'(gnt), 32'(e_gnt));
    check({tag, ".x"}, idx, 32'(vga_x), 32'(e_x));
    check({tag, ".y"}, idx, 32'(vga_y), 32'(e_y));
    check({tag, ".colour"}, idx, 32'(vga_colour), 32'(e_c));
    check({tag, ".plot"}, idx, 32'(vga_plot), 32'(e_p));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".gnt"}, 0, 32'(gnt), 32'd0);
    check({tag, ".x"}, 0, 32'(vga_x), 32'd0);
    check({tag, ".y"}, 0, 32'(vga_y), 32'd0);
    check({tag, ".colour"}, 0, 32'(vga_colour), 32'd0);
    check({tag, ".plot"}, 0, 32'(vga_plot), 32'd0);
  endtask

  logic [7:0] px;
  logic [6:0] py;
  logic [2:0] pc;
  logic [3:0] oh;
  logic [3:0] exp_g;

  initial begin
    total = 0;
    bad   = 0;

    //          en   req      plot     src x       y       c      gnt      ex      ey      ec    ep
    vecs[0]  = '{1'b1, 4'b0101, 4'b0000, 0, 8'd0,   7'd0,   3'd0, 4'b0001, 8'd0,   7'd0,   3'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'b0101, 4'b0001, 0, 8'd10,  7'd20,  3'd5, 4'b0001, 8'd10,  7'd20,  3'd5, 1'b1};
    vecs[2]  = '{1'b1, 4'b0100, 4'b0001, 0, 8'd11,  7'd21,  3'd6, 4'b0000, 8'd11,  7'd21,  3'd6, 1'b1};
    vecs[3]  = '{1'b1, 4'b0100, 4'b0000, 2, 8'd5,   7'd7,   3'd3, 4'b0100, 8'd11,  7'd21,  3'd6, 1'b0};
    vecs[4]  = '{1'b1, 4'b0100, 4'b0101, 2, 8'd5,   7'd7,   3'd3, 4'b0100, 8'd5,   7'd7,   3'd3, 1'b1};
    vecs[5]  = '{1'b1, 4'b0000, 4'b0000, 2, 8'd6,   7'd8,   3'd1, 4'b0000, 8'd6,   7'd8,   3'd1, 1'b0};
    vecs[6]  = '{1'b1, 4'b0000, 4'b0000, 2, 8'd6,   7'd8,   3'd1, 4'b0000, 8'd6,   7'd8,   3'd1, 1'b0};
    vecs[7]  = '{1'b1, 4'b1000, 4'b0000, 3, 8'd0,   7'd0,   3'd0, 4'b1000, 8'd6,   7'd8,   3'd1, 1'b0};
    vecs[8]  = '{1'b1, 4'b1000, 4'b1000, 3, 8'd160, 7'd10,  3'd2, 4'b1000, 8'd160, 7'd10,  3'd2, 1'b0};
    vecs[9]  = '{1'b1, 4'b1000, 4'b1000, 3, 8'd159, 7'd119, 3'd4, 4'b1000, 8'd159, 7'd119, 3'd4, 1'b1};
    vecs[10] = '{1'b1, 4'b1000, 4'b1000, 3, 8'd0,   7'd120, 3'd7, 4'b1000, 8'd0,   7'd120, 3'd7, 1'b0};
    vecs[11] = '{1'b1, 4'b0000, 4'b0000, 3, 8'd1,   7'd1,   3'd1, 4'b0000, 8'd1,   7'd1,   3'd1, 1'b0};
    vecs[12] = '{1'b1, 4'b0010, 4'b0000, 1, 8'd0,   7'd0,   3'd0, 4'b0010, 8'd1,   7'd1,   3'd1, 1'b0};
    vecs[13] = '{1'b1, 4'b0010, 4'b0010, 1, 8'd30,  7'd40,  3'd2, 4'b0010, 8'd30,  7'd40,  3'd2, 1'b1};
    vecs[14] = '{1'b0, 4'b0011, 4'b0010, 1, 8'd31,  7'd41,  3'd3, 4'b0000, 8'd31,  7'd41,  3'd3, 1'b1};
    vecs[15] = '{1'b0, 4'b0011, 4'b0000, 1, 8'd0,   7'd0,   3'd0, 4'b0000, 8'd31,  7'd41,  3'd3, 1'b0};
    vecs[16] = '{1'b1, 4'b0011, 4'b0000, 0, 8'd0,   7'd0,   3'd0, 4'b0001, 8'd31,  7'd41,  3'd3, 1'b0};
    vecs[17] = '{1'b1, 4'b0000, 4'b0001, 0, 8'd50,  7'd60,  3'd5, 4'b0000, 8'd50,  7'd60,  3'd5, 1'b1};

    // Reset held with requests pending: nothing may be granted or plotted.
    resetn = 1'b0;
    drive(1'b1, 4'b0101, 4'b0101, 0, 8'd10, 7'd20, 3'd5);
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].en, vecs[i].rq, vecs[i].pl, vecs[i].src, vecs[i].x, vecs[i].y, vecs[i].c);
      step_check("vec", i, vecs[i].e_gnt, vecs[i].e_x, vecs[i].e_y, vecs[i].e_c, vecs[i].e_p);
    end

    // Asynchronous reset in the middle of requester 2's burst.
    drive(1'b1, 4'b0100, 4'b0000, 2, 8'd0, 7'd0, 3'd0);
    step_check("midrst_grant", 0, 4'b0100, 8'd50, 7'd60, 3'd5, 1'b0);
    drive(1'b1, 4'b0100, 4'b0100, 2, 8'd70, 7'd80, 3'd6);
    step_check("midrst_pix", 0, 4'b0100, 8'd70, 7'd80, 3'd6, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clock);
    resetn = 1'b1;

    // Round-robin: everyone requests, each owner drops after its third pixel.
    px = 8'd0; py = 7'd0; pc = 3'd0;
    for (int r = 0; r < 5; r++) begin
      int k;
      k  = r % 4;
      oh = 4'b0001 << k;
      drive(1'b1, 4'b1111, 4'b0000, k, 8'd0, 7'd0, 3'd0);
      step_check("rr_grant", r, oh, px, py, pc, 1'b0);
      for (int j = 0; j < 3; j++) begin
        px = 8'(k * 10 + j + 1);
        py = 7'(k + j + 1);
        pc = 3'(k + j);
        drive(1'b1, (j == 2) ? (4'b1111 & ~oh) : 4'b1111, oh, k, px, py, pc);
        step_check("rr_pix", r * 3 + j, (j == 2) ? 4'b0000 : oh, px, py, pc, 1'b1);
      end
    end

    // Hold limit: req0 from cycle 0, competitor req1 from cycle 2.
    @(negedge clock);
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, (c >= 2) ? 4'b0011 : 4'b0001, 4'b0000, 0, 8'd1, 7'd1, 3'd1);
      @(posedge clock);
      #1;
`ifdef VGA_ARB_TIMEOUT_EN
      if (c <= 7)      exp_g = 4'b0001;
      else if (c == 8) exp_g = 4'b0000;
      else             exp_g = 4'b0010;
`else
      exp_g = 4'b0001;
`endif
      check("hold.gnt", c, 32'(gnt), 32'(exp_g));
      check("hold.plot", c, 32'(vga_plot), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
